// File: rtl/speck_pkg.sv
// Shared SPECK128/128 constants, scheduler state encoding and word rotations.
package speck_pkg;

    localparam int WORD   = 64;
    localparam int ROUNDS = 32;
    localparam int ALPHA  = 8;
    localparam int BETA   = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_READY  = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_RESP   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] x, input int n);
        return (x << n) | (x >> (WORD - n));
    endfunction

endpackage

// File: rtl/speck_round_scheduler_if.sv
// Block request/response channel between the cipher top level and the round scheduler.
interface speck_round_scheduler_if
    import speck_pkg::*;
;
    logic              req_valid;
    logic              req_ready;
    logic              req_decrypt;
    logic [2*WORD-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*WORD-1:0] rsp_data;
    logic              rsp_error;

    modport master (
        output req_valid, req_decrypt, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_decrypt, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );

endinterface

// File: rtl/speck_key_expand.sv
// One combinational SPECK128/128 key-schedule step: (k, l, i) -> (k', l').
module speck_key_expand
    import speck_pkg::*;
(
    input  logic [WORD-1:0] k_i,
    input  logic [WORD-1:0] l_i,
    input  logic [4:0]      idx_i,
    output logic [WORD-1:0] k_o,
    output logic [WORD-1:0] l_o
);

    assign l_o = (k_i + ror(l_i, ALPHA)) ^ {{(WORD-5){1'b0}}, idx_i};
    assign k_o = rol(k_i, BETA) ^ l_o;

endmodule

// File: rtl/speck_round_scheduler.sv
// Drives a shared single-round SPECK128/128 core through all rounds using a local round-key buffer.
// Optional per-round watchdog enabled by defining SPECK_ROUND_WATCHDOG_EN.
module speck_round_scheduler
    import speck_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_load,
    input  logic [2*WORD-1:0]      key,
    output logic                   key_ready,
    speck_round_scheduler_if.slave bus,
    output logic                   core_start,
    output logic                   core_decrypt,
    output logic [WORD-1:0]        core_subkey,
    output logic [2*WORD-1:0]      core_din,
    input  logic [2*WORD-1:0]      core_dout,
    input  logic                   core_finished,
    output logic [4:0]             round_idx
);

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [WORD-1:0]   k_q, k_d, l_q, l_d, k_nx_s, l_nx_s;
    logic [4:0]        r_q, r_d;
    logic              dec_q, dec_d;
    logic [2*WORD-1:0] blk_q, blk_d;
    logic              key_ready_q, key_ready_d;
    logic              buf_we_s, busy_s, last_s;
    logic [WORD-1:0]   rk_buf [ROUNDS];

    logic              req_ready_q, rsp_valid_q, core_start_q, core_decrypt_q;
    logic [WORD-1:0]   core_subkey_q;
    logic [2*WORD-1:0] core_din_q, rsp_data_q;
    logic [4:0]        round_idx_q;

`ifdef SPECK_ROUND_WATCHDOG_EN
    localparam int             WDW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           rsp_error_q;
`endif

    speck_key_expand u_key_expand (
        .k_i   (k_q),
        .l_i   (l_q),
        .idx_i (r_q),
        .k_o   (k_nx_s),
        .l_o   (l_nx_s)
    );

    assign busy_s = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_RESP);
    assign last_s = dec_q ? (r_q == 5'd0) : (r_q == LAST_IDX);

    // Next-state, key schedule and round-index sequencing.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        l_d         = l_q;
        r_d         = r_q;
        dec_d       = dec_q;
        blk_d       = blk_q;
        key_ready_d = key_ready_q;
        buf_we_s    = 1'b0;
`ifdef SPECK_ROUND_WATCHDOG_EN
        wd_d        = wd_q;
`endif
        if (key_load && !busy_s) begin
            k_d         = key[WORD-1:0];
            l_d         = key[2*WORD-1:WORD];
            r_d         = 5'd0;
            key_ready_d = 1'b0;
            state_d     = S_KEYEXP;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_KEYEXP: begin
                    buf_we_s = 1'b1;
                    k_d      = k_nx_s;
                    l_d      = l_nx_s;
                    if (r_q == LAST_IDX) begin
                        r_d         = 5'd0;
                        key_ready_d = 1'b1;
                        state_d     = S_READY;
                    end else begin
                        r_d = r_q + 5'd1;
                    end
                end
                S_READY: begin
                    if (bus.req_valid) begin
                        blk_d   = bus.req_data;
                        dec_d   = bus.req_decrypt;
                        r_d     = bus.req_decrypt ? LAST_IDX : 5'd0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_READY;
                    end
                end
                S_ISSUE: begin
`ifdef SPECK_ROUND_WATCHDOG_EN
                    wd_d = '0;
`endif
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (core_finished) begin
                        blk_d = core_dout;
                        if (last_s) begin
                            state_d = S_RESP;
                        end else begin
                            r_d     = dec_q ? (r_q - 5'd1) : (r_q + 5'd1);
                            state_d = S_ISSUE;
                        end
                    end else begin
`ifdef SPECK_ROUND_WATCHDOG_EN
                        if (wd_q == WD_LAST) begin
                            state_d = S_ERR;
                        end else begin
                            wd_d = wd_q + WDW'(1);
                        end
`else
                        state_d = S_WAIT;
`endif
                    end
                end
                S_RESP, S_ERR: begin
                    if (bus.rsp_ready) begin
                        state_d = S_READY;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            l_q         <= '0;
            r_q         <= 5'd0;
            dec_q       <= 1'b0;
            blk_q       <= '0;
            key_ready_q <= 1'b0;
`ifdef SPECK_ROUND_WATCHDOG_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            l_q         <= l_d;
            r_q         <= r_d;
            dec_q       <= dec_d;
            blk_q       <= blk_d;
            key_ready_q <= key_ready_d;
`ifdef SPECK_ROUND_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
        end
    end

    // Round-key buffer, filled one entry per expansion cycle.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            rk_buf[r_q] <= k_q;
        end
    end

    // Outputs registered from the next state so they always match the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            core_start_q   <= 1'b0;
            core_decrypt_q <= 1'b0;
            core_subkey_q  <= '0;
            core_din_q     <= '0;
            round_idx_q    <= 5'd0;
`ifdef SPECK_ROUND_WATCHDOG_EN
            rsp_error_q    <= 1'b0;
`endif
        end else begin
            req_ready_q    <= (state_d == S_READY);
            rsp_valid_q    <= (state_d == S_RESP) || (state_d == S_ERR);
            rsp_data_q     <= (state_d == S_RESP) ? blk_d : '0;
            core_start_q   <= (state_d == S_ISSUE);
            core_decrypt_q <= dec_d;
            round_idx_q    <= r_d;
            if (state_d == S_ISSUE) begin
                core_subkey_q <= rk_buf[r_d];
                core_din_q    <= blk_d;
            end
`ifdef SPECK_ROUND_WATCHDOG_EN
            rsp_error_q    <= (state_d == S_ERR);
`endif
        end
    end

    assign key_ready     = key_ready_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef SPECK_ROUND_WATCHDOG_EN
    assign bus.rsp_error = rsp_error_q;
`else
    assign bus.rsp_error = 1'b0;
`endif
    assign core_start    = core_start_q;
    assign core_decrypt  = core_decrypt_q;
    assign core_subkey   = core_subkey_q;
    assign core_din      = core_din_q;
    assign round_idx     = round_idx_q;

endmodule

// File: tb/tb_speck_round_scheduler.sv
// Directed bench for speck_round_scheduler with a behavioural SPECK128/128 round core.
module tb_speck_round_scheduler;

    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] PT  = 128'h6c61766975716520_7469206564616d20;
    localparam logic [127:0] CT  = 128'ha65d985179783265_7860fedf5c570d18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_load = 1'b0;
    logic [127:0] key = KEY;
    logic         key_ready, core_start, core_decrypt;
    logic [63:0]  core_subkey;
    logic [127:0] core_din;
    logic [4:0]   round_idx;

    logic         core_finished = 1'b0;
    logic [127:0] core_dout = '0;
    logic [127:0] core_res = '0;
    logic         core_busy = 1'b0;
    int           core_cnt = 0;
    int           core_lat = 2;
    bit           core_dead = 1'b0;
    bit           spur_en = 1'b0;
    logic         fin_s;
    logic [127:0] dout_s;

    int           n_cmp = 0;
    int           n_mis = 0;
    int           n_start = 0;
    logic [63:0]  sk_log [256];
    logic [4:0]   idx_log [256];

    speck_round_scheduler_if bus ();

    always #5 clk = ~clk;

    // Spurious finished pulses land only in the ISSUE cycle, carrying garbage data.
    assign fin_s  = core_finished | (spur_en & core_start);
    assign dout_s = (spur_en && core_start) ? 128'hdeadbeef_deadbeef_deadbeef_deadbeef : core_dout;

    speck_round_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .key_load      (key_load),
        .key           (key),
        .key_ready     (key_ready),
        .bus           (bus),
        .core_start    (core_start),
        .core_decrypt  (core_decrypt),
        .core_subkey   (core_subkey),
        .core_din      (core_din),
        .core_dout     (dout_s),
        .core_finished (fin_s),
        .round_idx     (round_idx)
    );

    function automatic logic [127:0] speck_rnd(input logic [127:0] b, input logic [63:0] k, input logic dec);
        logic [63:0] x, y;
        x = b[127:64];
        y = b[63:0];
        if (!dec) begin
            x = ({x[7:0], x[63:8]} + y) ^ k;
            y = {y[60:0], y[63:61]} ^ x;
        end else begin
            y = y ^ x;
            y = {y[2:0], y[63:3]};
            x = (x ^ k) - y;
            x = {x[55:0], x[63:56]};
        end
        return {x, y};
    endfunction

    always @(posedge clk) begin
        core_finished <= 1'b0;
        if (core_start) begin
            core_res  <= speck_rnd(core_din, core_subkey, core_decrypt);
            core_cnt  <= core_lat;
            core_busy <= !core_dead;
        end else if (core_busy) begin
            if (core_cnt <= 1) begin
                core_finished <= 1'b1;
                core_dout     <= core_res;
                core_busy     <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (core_start && n_start < 256) begin
            sk_log[n_start]  <= core_subkey;
            idx_log[n_start] <= round_idx;
        end
        if (core_start) begin
            n_start <= n_start + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic dec, input logic [127:0] data);
        int n;
        n = 0;
        bus.req_valid   = 1'b1;
        bus.req_decrypt = dec;
        bus.req_data    = data;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("req_accept_timeout", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int cyc);
        cyc = 0;
        while (!bus.rsp_valid && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.rsp_valid) check_eq("rsp_timeout", bus.rsp_valid, 1);
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic load_key(input string tag);
        int n;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 128'(n), 128'd32);
    endtask

    initial begin
        int cyc, ebase, dbase, base;
        bus.req_valid   = 1'b0;
        bus.req_decrypt = 1'b0;
        bus.req_data    = '0;
        bus.rsp_ready   = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_key_ready", key_ready, 0);
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_core_start", core_start, 0);
        rst = 1'b0;
        @(negedge clk);

        // Key expansion latency and first round key.
        load_key("keyexp_latency");
        check_eq("req_ready_after_keyexp", bus.req_ready, 1);

        // Encryption with the reference vector.
        ebase = n_start;
        do_req(1'b0, PT);
        wait_rsp(500, cyc);
        check_eq("enc_data", bus.rsp_data, CT);
        check_eq("enc_error", bus.rsp_error, 0);
        check_eq("enc_starts", 128'(n_start - ebase), 128'd32);
        check_eq("enc_subkey0", sk_log[ebase], 128'h0706050403020100);
        for (int i = 0; i < 32; i++) check_eq($sformatf("enc_idx%0d", i), idx_log[ebase + i], 128'(i));

        // Backpressure: response held, competing request and key_load not accepted.
        base = n_start;
        bus.req_valid   = 1'b1;
        bus.req_decrypt = 1'b1;
        bus.req_data    = CT;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                key_load = 1'b1;
                key      = '0;
            end else begin
                key_load = 1'b0;
                key      = KEY;
            end
            @(negedge clk);
            check_eq("bp_rsp_valid", bus.rsp_valid, 1);
            check_eq("bp_rsp_data", bus.rsp_data, CT);
            check_eq("bp_req_ready", bus.req_ready, 0);
        end
        check_eq("bp_no_start", 128'(n_start - base), 128'd0);
        release_rsp();
        check_eq("bp_key_ready_kept", key_ready, 1);
        check_eq("bp_rsp_dropped", bus.rsp_valid, 0);
        check_eq("bp_req_ready", bus.req_ready, 1);
        dbase = n_start;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_eq("dec_first_start", core_start, 1);

        // Decryption walks the round keys backwards.
        wait_rsp(500, cyc);
        check_eq("dec_data", bus.rsp_data, PT);
        check_eq("dec_starts", 128'(n_start - dbase), 128'd32);
        for (int i = 0; i < 32; i++) begin
            check_eq($sformatf("dec_idx%0d", i), idx_log[dbase + i], 128'(31 - i));
            check_eq($sformatf("dec_sk%0d", i), sk_log[dbase + i], sk_log[ebase + 31 - i]);
        end
        release_rsp();

        // Spurious finished during ISSUE must be ignored.
        spur_en  = 1'b1;
        core_lat = 1;
        do_req(1'b0, PT);
        wait_rsp(500, cyc);
        check_eq("spur_enc_data", bus.rsp_data, CT);
        release_rsp();
        spur_en  = 1'b0;
        core_lat = 2;

        // Reset while waiting on round 5.
        do_req(1'b0, PT);
        cyc = 0;
        while (!(round_idx == 5'd5 && !core_start) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach_round5", round_idx, 5);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_key_ready", key_ready, 0);
        check_eq("arst_req_ready", bus.req_ready, 0);
        check_eq("arst_round_idx", round_idx, 0);
        check_eq("arst_core_din", core_din, 0);
        check_eq("arst_core_subkey", core_subkey, 0);
        @(negedge clk);
        rst  = 1'b0;
        base = n_start;
        bus.req_valid   = 1'b1;
        bus.req_decrypt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("post_rst_req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        check_eq("post_rst_no_start", 128'(n_start - base), 128'd0);
        load_key("rekey_latency");

        // Core that never finishes.
        core_dead = 1'b1;
        do_req(1'b0, PT);
`ifdef SPECK_ROUND_WATCHDOG_EN
        wait_rsp(60, cyc);
        check_eq("wd_latency", 128'(cyc), 128'd16);
        check_eq("wd_error", bus.rsp_error, 1);
        check_eq("wd_data", bus.rsp_data, 0);
        release_rsp();
        check_eq("wd_back_ready", bus.req_ready, 1);
`else
        cyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) cyc++;
        end
        check_eq("nowd_no_rsp", 128'(cyc), 128'd0);
        check_eq("nowd_error", bus.rsp_error, 0);
`endif
        core_dead = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/speck_round_scheduler.md
Name: speck_round_scheduler

Overview:
- Sequences one shared single-round SPECK128/128 core (encrypt/decrypt round with clk/signal_start/subkey/finished handshake) through all 32 rounds.
- Expands the 128-bit master key into 32 round keys held in a local buffer.
- Feeds each round's result back as the next round's input, walking keys forward for encryption and backward for decryption.
- Sits between the block-cipher top level and the round core.

Parameters:
- ROUNDS, 32, number of rounds and round-key buffer depth.
- WORD, 64, SPECK word width; block = 2*WORD, key = 2*WORD.
- TIMEOUT_CYC, 15, watchdog limit in cycles per round (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- key_load  in  1  pulse: latch key and start expansion.
- key  in  128  master key; [127:64]=l0, [63:0]=k0.
- key_ready  out  1  round-key buffer valid.
- req_valid  in  1  block request.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_decrypt  in  1  0=encrypt, 1=decrypt (sampled on accept).
- req_data  in  128  input block; [127:64]=x, [63:0]=y.
- rsp_valid  out  1  result valid, held until rsp_ready.
- rsp_ready  in  1  consumer accepts.
- rsp_data  out  128  result block.
- rsp_error  out  1  result aborted (timeout only).
- core_start  out  1  one-cycle start to round core (drives signal_start).
- core_decrypt  out  1  selects decrypt round core.
- core_subkey  out  64  round key for current round.
- core_din  out  128  round input block.
- core_dout  in  128  round output block.
- core_finished  in  1  round done; core_dout valid same cycle.
- round_idx  out  5  current round number (debug).

Behaviour:
- Reset values: every output 0; FSM in IDLE; buffer contents don't-care, key_ready=0.
- FSM states: IDLE, KEYEXP, READY, ISSUE, WAIT, RESP, ERR.
- Key expansion
  - key_load (any state except ISSUE/WAIT/RESP) latches k=key[63:0], l=key[127:64], clears key_ready and enters KEYEXP.
  - Each KEYEXP cycle i (0..ROUNDS-1) writes buf[i]=k, then updates l'=(k+ROR(l,8))^i and k'=ROL(k,3)^l'.
  - Addition is mod 2^64; i is zero-extended.
  - After 32 cycles: key_ready=1, go to READY.
  - key_load while busy (ISSUE/WAIT/RESP) is ignored.
- Request handshake
  - req_ready=1 only in READY.
  - On accept, latch data and mode; r=0 for encrypt, r=31 for decrypt; go to ISSUE.
- Round loop
  - ISSUE: core_start=1 for exactly one cycle; core_subkey=buf[r], core_din=working block; then WAIT.
  - core_subkey and core_din stay stable through WAIT.
  - WAIT: on core_finished, working block<=core_dout.
    - Last round (r=31 encrypt / r=0 decrypt): go to RESP.
    - Otherwise step r (+1 encrypt, -1 decrypt) and return to ISSUE.
  - Per-round cost: 1 cycle + core latency.
- Response
  - RESP: rsp_valid=1, rsp_data=working block, rsp_error=0.
  - Hold until rsp_ready; then return to READY (same cycle rsp_ready sampled high).
  - rsp_valid and req_ready are never both 1.
- Boundary conditions
  - core_finished outside WAIT is ignored.
  - core_finished coincident with core_start (ISSUE) is ignored.
  - Decrypt index never wraps below 0; encrypt index never exceeds 31.
- Reset mid-operation aborts immediately; a new key_load is needed before any request.

Optional Feature:
- SPECK_ROUND_WATCHDOG_EN
- Defined:
  - A cycle counter runs in WAIT.
  - If core_finished has not arrived after TIMEOUT_CYC cycles, go to ERR.
  - ERR presents rsp_valid=1, rsp_error=1, rsp_data=0, then returns to READY on rsp_ready.
- Undefined: no counter; WAIT waits forever; rsp_error is tied 0.

Decomposition:
- Package speck_pkg holds:
  - WORD, ROUNDS, ALPHA=8, BETA=3 constants.
  - FSM state enum.
  - ror/rol functions.
- One sub-module, speck_key_expand: one combinational key-schedule step (k,l,i)->(k',l').
- Buffer, FSM and counters stay in the scheduler.

Test Plan:
- Key expansion: key=0f0e0d0c0b0a0908_0706050403020100 -> key_ready rises 32 cycles after key_load; buf[0]=0706050403020100.
- Encryption: key as above, encrypt req_data=6c61766975716520_7469206564616d20 with the real round core -> rsp_data=a65d985179783265_7860fedf5c570d18; exactly 32 core_start pulses; round_idx 0..31.
- Decryption: same key, decrypt a65d985179783265_7860fedf5c570d18 -> 6c61766975716520_7469206564616d20; subkeys issued buf[31] down to buf[0].
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=0; a req_valid or key_load presented meanwhile is not accepted; then accepted after rsp_ready.
- Reset mid-operation: assert rst during round 5 WAIT -> all outputs 0 asynchronously, key_ready=0, req_ready=0 until a new key expansion completes.
- Watchdog (SPECK_ROUND_WATCHDOG_EN): stub core never raises core_finished -> rsp_valid=1, rsp_error=1 after TIMEOUT_CYC cycles in WAIT; without the macro, rsp_valid stays 0.
